muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle controller for the HI/LO multiply/divide resource of the MIPS core.
- Accepts decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo strobes from the decode stage, sequences a 32-iteration shift-add/restoring-divide datapath and owns the HI/LO registers.
- Stalls the pipeline while a result is pending; supports flush on exception or eret.

Parameters:
- WIDTH, 32, operand and HI/LO width
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- mult  in  1  decoded signed multiply strobe
- multu  in  1  decoded unsigned multiply strobe
- div  in  1  decoded signed divide strobe
- divu  in  1  decoded unsigned divide strobe
- mthi  in  1  decoded move-to-HI strobe
- mtlo  in  1  decoded move-to-LO strobe
- mfhi  in  1  decoded move-from-HI strobe
- mflo  in  1  decoded move-from-LO strobe
- flush  in  1  exception/eret cancel of the in-flight op
- rs_val  in  WIDTH  rs operand
- rt_val  in  WIDTH  rt operand
- stall  out  1  hold the issuing stage this cycle
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO are updated by an op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- mf_data  out  WIDTH  HI when mfhi is high, LO when mflo is high, else 0

Behaviour:
- Reset: state IDLE, counter 0, hi=lo=0, busy=done=stall=0, all datapath registers 0. Applies mid-operation; the pending result is discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- Issue: in IDLE with any of mult/multu/div/divu high and flush low, operands latch at edge E0. Signed ops latch absolute values, result signs (quotient sign = rs^rt, remainder sign = rs), and the op type. State -> CALC, counter = 0.
- CALC: one iteration per cycle, 32 cycles, counter 0..31. At edge E32 state -> FIX.
- FIX: sign correction only. At E33 hi/lo are written, done=1 for the following cycle, state -> IDLE.
- Latency: the result is readable by mfhi/mflo in the cycle after E33.
- busy: high from E0 to E33 (inclusive of the FIX cycle).
- stall: combinational, = busy & (any md op | mthi | mtlo | mfhi | mflo).
  - A stalled strobe is not accepted and must be re-presented.
  - Ops issuing from IDLE never stall.
- Results:
  - mult/multu: {hi,lo} = 64-bit product.
  - div/divu: lo = quotient, hi = remainder; remainder takes the sign of the dividend.
- Divide by zero (decided): lo = 32'hFFFFFFFF, hi = rs_val as latched. No trap. Full latency still applies.
- Overflow case div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi/mtlo: when not busy, write rs_val at the next edge; no done pulse.
- Strobe priority: if more than one strobe is high (protocol violation), priority is md op > mthi > mtlo.
- mfhi/mflo: read-only and combinational. When not busy, mf_data reflects hi/lo including a same-cycle mthi/mtlo write only after the edge; no bypass.
- flush:
  - In CALC/FIX: state -> IDLE at the next edge; hi/lo unchanged; no done pulse.
  - Same cycle as an issue: flush wins and nothing is latched.
  - Flush blocks mthi/mtlo writes in the same cycle.
- done and a new issue may coincide: a new op is accepted in the cycle done is high, since state is IDLE.

Decomposition:
- Shared package:
  - state encoding (IDLE/CALC/FIX)
  - op-type encoding (MUL_S, MUL_U, DIV_S, DIV_U)
  - ITER_LAST constant (31)
  - DIV0_QUOT constant (all ones)
- Natural sub-module: muldiv_iter, the pure datapath for one iteration step.
  - Holds the accumulator/remainder, shifts the multiplier/quotient, and applies a step enable and a mode select.
  - The FSM, counter, sign fix, HI/LO and stall logic stay in muldiv_ctrl.

Test Plan:
- mult rs=0xFFFFFFFF rt=0x00000002 -> done 34 cycles after issue; hi=0xFFFFFFFF, lo=0xFFFFFFFE. The same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7 rt=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- mflo held high from the cycle after issue -> stall=1 for exactly 33 cycles, then stall=0 and mf_data = new lo. mthi 0x1234 while busy -> stalled, hi unchanged until accepted after busy drops.
- flush at CALC counter 10 -> busy drops after the edge, no done pulse, hi/lo retain the prior values (e.g. 0xAAAA/0x5555 set via mthi/mtlo).
- rst_n=0 for one cycle mid-CALC -> hi=lo=0, busy=0, stall=0 next cycle. A fresh multu 3*5 then gives lo=15, hi=0.
- Back-to-back: a second mult presented during the done cycle is accepted without a stall; its result arrives 34 cycles later.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
//   state_t   : controller FSM encoding (IDLE -> CALC -> FIX -> IDLE)
//   op_t      : latched operation type
//   ITER_LAST : counter value of the final shift-add / restoring step
//   DIV0_QUOT : quotient reported for a divide by zero
package muldiv_ctrl_pkg;

    localparam int MD_WIDTH  = 32;
    localparam int ITER_LAST = MD_WIDTH - 1;

    localparam logic [MD_WIDTH-1:0] DIV0_QUOT = {MD_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MUL_S = 2'd0,
        MUL_U = 2'd1,
        DIV_S = 2'd2,
        DIV_U = 2'd3
    } op_t;

    function automatic logic op_is_div(input op_t op);
        return (op == DIV_S) || (op == DIV_U);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath shared by multiply and divide.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture a_in into mq, b_in as the operand, clear acc
//   step       : perform one iteration
//   mode_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   a_in, b_in : multiplier/dividend and multiplicand/divisor (unsigned)
//   acc        : product high half / remainder
//   mq         : product low half  / quotient
// After WIDTH steps {acc, mq} holds the product, or acc = remainder and
// mq = quotient.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mq
);

    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        acc_n     = acc;
        mq_n      = mq;
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        div_shift = {acc, mq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (mode_div) begin
            // Top bit of the difference is the borrow: set means the
            // trial subtraction failed and the shifted remainder is kept.
            if (!div_diff[WIDTH]) begin
                acc_n = div_diff[WIDTH-1:0];
                mq_n  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = div_shift[WIDTH-1:0];
                mq_n  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add-then-shift: the carry out of the add becomes the new
            // top bit of acc, and acc's low bit moves into mq.
            acc_n = mul_sum[WIDTH:1];
            mq_n  = {mul_sum[0], mq[WIDTH-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            mq  <= '0;
            opb <= '0;
        end else if (load) begin
            acc <= '0;
            mq  <= a_in;
            opb <= b_in;
        end else if (step) begin
            acc <= acc_n;
            mq  <= mq_n;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller for the MIPS core.
//   clk, rst_n          : clock, synchronous active-low reset
//   mult/multu/div/divu : decoded multiply/divide strobes
//   mthi/mtlo           : decoded move-to-HI/LO strobes (write rs_val)
//   mfhi/mflo           : decoded move-from-HI/LO strobes (select mf_data)
//   flush               : exception/eret cancel of the in-flight op
//   rs_val, rt_val      : operands
//   stall               : hold the issuing stage (busy and a strobe present)
//   busy                : operation in flight (CALC or FIX)
//   done                : one-cycle pulse after HI/LO are written by an op
//   hi, lo              : HI/LO registers
//   mf_data             : HI for mfhi, LO for mflo, else 0
// Signed ops run on magnitudes; the sign is reapplied in the FIX cycle.
// WIDTH must equal MD_WIDTH from the package.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mult,
    input  logic             multu,
    input  logic             div,
    input  logic             divu,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    op_t              op, req_op;
    logic             q_neg, r_neg, div_zero;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             done_n;

    logic             md_req, issue, req_signed;
    logic [WIDTH-1:0] abs_rs, abs_rt;
    logic [WIDTH-1:0] acc, mq;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign md_req = mult | multu | div | divu;
    assign busy   = (state != ST_IDLE);
    assign stall  = busy & (md_req | mthi | mtlo | mfhi | mflo);
    assign issue  = (state == ST_IDLE) & md_req & ~flush;

    assign mf_data = mfhi ? hi : (mflo ? lo : '0);

    // Several md strobes at once is a protocol violation; resolve it
    // deterministically in declaration order.
    always_comb begin
        req_op = DIV_U;
        if (mult)       req_op = MUL_S;
        else if (multu) req_op = MUL_U;
        else if (div)   req_op = DIV_S;
        req_signed = (req_op == MUL_S) || (req_op == DIV_S);
        abs_rs = (req_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        abs_rt = (req_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (issue),
        .step     (state == ST_CALC),
        .mode_div (op_is_div(op)),
        .a_in     (abs_rs),
        .b_in     (abs_rt),
        .acc      (acc),
        .mq       (mq)
    );

    // Sign correction applied in FIX. q_neg doubles as the product sign.
    always_comb begin
        prod_fix = q_neg ? -{acc, mq} : {acc, mq};
        quot_fix = div_zero ? DIV0_QUOT : (q_neg ? -mq : mq);
        // With a zero divisor acc ends as |rs|; restoring rs's sign gives
        // back the dividend exactly.
        rem_fix  = r_neg ? -acc : acc;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!flush) begin
                    if (md_req) begin
                        state_n = ST_CALC;
                        cnt_n   = '0;
                    end else if (mthi) begin
                        hi_n = rs_val;
                    end else if (mtlo) begin
                        lo_n = rs_val;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(ITER_LAST)) begin
                    state_n = ST_FIX;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_FIX: begin
                state_n = ST_IDLE;
                if (!flush) begin
                    done_n = 1'b1;
                    if (op_is_div(op)) begin
                        hi_n = rem_fix;
                        lo_n = quot_fix;
                    end else begin
                        hi_n = prod_fix[2*WIDTH-1:WIDTH];
                        lo_n = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            op       <= MUL_S;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            done  <= done_n;
            if (issue) begin
                op       <= req_op;
                q_neg    <= req_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                r_neg    <= req_signed & rs_val[WIDTH-1];
                div_zero <= (rt_val == '0);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, mult, multu, div, divu;
    logic        mthi, mtlo, mfhi, mflo, flush;
    logic [31:0] rs_val, rt_val;
    logic        stall, busy, done;
    logic [31:0] hi, lo, mf_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .mult(mult), .multu(multu), .div(div), .divu(divu),
        .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
        .flush(flush), .rs_val(rs_val), .rt_val(rt_val),
        .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // code: 0 mult, 1 multu, 2 div, 3 divu. Returns one cycle after E0.
    task automatic issue(input int code, input logic [31:0] a, input logic [31:0] b);
        rs_val = a;
        rt_val = b;
        mult   = (code == 0);
        multu  = (code == 1);
        div    = (code == 2);
        divu   = (code == 3);
        tick();
        mult = 1'b0; multu = 1'b0; div = 1'b0; divu = 1'b0;
    endtask

    // Counts cycles after the issue cycle until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    int lat;
    int pulses;

    initial begin
        rst_n = 1'b0;
        {mult, multu, div, divu, mthi, mtlo, mfhi, mflo, flush} = '0;
        rs_val = '0;
        rt_val = '0;
        tick();
        tick();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst_n = 1'b1;
        tick();

        // Signed and unsigned multiply of the same bit patterns
        issue(0, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_busy", 32'(busy), 32'h1);
        wait_done(lat);
        check("mult_latency", 32'(lat), 32'd34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        check("mult_busy_done", 32'(busy), 32'h0);
        tick();
        check("done_one_cycle", 32'(done), 32'h0);

        issue(1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_done(lat);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // Divides: signed with negative dividend, by zero, overflow
        issue(2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(lat);
        check("div_latency", 32'(lat), 32'd34);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(3, 32'h0000_0007, 32'h0000_0000);
        wait_done(lat);
        check("divu0_latency", 32'(lat), 32'd34);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'h0000_0007);

        issue(2, 32'hFFFF_FFF9, 32'h0000_0000);
        wait_done(lat);
        check("div0_neg_lo", lo, 32'hFFFF_FFFF);
        check("div0_neg_hi", hi, 32'hFFFF_FFF9);

        issue(2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        // mthi with a same-cycle mfhi: no bypass
        tick();
        rs_val = 32'h0000_BEEF;
        mthi = 1'b1;
        mfhi = 1'b1;
        #1;
        check("mfhi_no_bypass", mf_data, 32'h0000_0000);
        tick();
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h0000_BEEF);
        check("mfhi_after", mf_data, 32'h0000_BEEF);
        mfhi = 1'b0;

        // mthi beats mtlo when both are presented
        rs_val = 32'h0000_0077;
        mthi = 1'b1;
        mtlo = 1'b1;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("prio_hi", hi, 32'h0000_0077);
        check("prio_lo", lo, 32'h8000_0000);

        // mflo held through an op: 33 stall cycles, then new lo
        issue(1, 32'd3, 32'd5);
        mflo = 1'b1;
        #1;
        lat = 0;
        while (stall && lat < 100) begin
            lat++;
            tick();
        end
        check("mflo_stall_cycles", 32'(lat), 32'd33);
        check("mflo_done", 32'(done), 32'h1);
        check("mflo_data", mf_data, 32'd15);
        mflo = 1'b0;

        // mthi while busy is stalled and only lands after busy drops
        rs_val = 32'h0000_BEEF;
        mthi = 1'b1;
        tick();
        mthi = 1'b0;
        issue(0, 32'd6, 32'd7);
        rs_val = 32'h0000_1234;
        mthi = 1'b1;
        #1;
        check("mthi_stalled", 32'(stall), 32'h1);
        repeat (10) tick();
        check("mthi_busy_hi", hi, 32'h0000_BEEF);
        lat = 0;
        while (busy && lat < 100) begin
            lat++;
            tick();
        end
        check("mthi_wait_bound", 32'(lat < 100), 32'h1);
        check("mthi_pre_hi", hi, 32'h0000_0000);
        check("mthi_pre_stall", 32'(stall), 32'h0);
        tick();
        mthi = 1'b0;
        check("mthi_accepted", hi, 32'h0000_1234);

        // flush at CALC counter 10
        rs_val = 32'h0000_AAAA;
        mthi = 1'b1;
        tick();
        mthi = 1'b0;
        rs_val = 32'h0000_5555;
        mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        check("pre_flush_lo", lo, 32'h0000_5555);
        issue(0, 32'd7, 32'd9);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'h0);
        pulses = 0;
        repeat (40) begin
            pulses += int'(done);
            tick();
        end
        check("flush_no_done", 32'(pulses), 32'h0);
        check("flush_hi", hi, 32'h0000_AAAA);
        check("flush_lo", lo, 32'h0000_5555);

        // flush on the issue cycle, and flush blocking mthi
        flush = 1'b1;
        issue(0, 32'd7, 32'd9);
        check("flush_issue_busy", 32'(busy), 32'h0);
        rs_val = 32'h0000_DEAD;
        mthi = 1'b1;
        tick();
        mthi = 1'b0;
        flush = 1'b0;
        check("flush_mthi_hi", hi, 32'h0000_AAAA);

        // reset mid-CALC, then a fresh multu
        issue(0, 32'd7, 32'd9);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);
        issue(1, 32'd3, 32'd5);
        wait_done(lat);
        check("post_rst_lo", lo, 32'd15);
        check("post_rst_hi", hi, 32'd0);

        // back-to-back: second mult accepted in the done cycle
        issue(0, 32'd7, 32'd9);
        wait_done(lat);
        check("b2b_first_lo", lo, 32'd63);
        check("b2b_first_done", 32'(done), 32'h1);
        mult = 1'b1;
        #1;
        check("b2b_no_stall", 32'(stall), 32'h0);
        issue(0, 32'hFFFF_FFFD, 32'd4);
        check("b2b_busy", 32'(busy), 32'h1);
        wait_done(lat);
        check("b2b_latency", 32'(lat), 32'd34);
        check("b2b_hi", hi, 32'hFFFF_FFFF);
        check("b2b_lo", lo, 32'hFFFF_FFF4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
